axi_rd_arbiter3: RTL and testbench

- Round-robin arbiter that shares the single AXI read (AR/R) channel among three read masters: 0 = icache, 1 = dcache, 2 = uncached data path.
- Sits between the cache/uncached bridges and the outer AXI read port, below the cache level in mycpu_top.
- Serves one read burst at a time, tags it with an arid equal to the master index, and routes returning beats to the owner.
- Checks beat count and rid, and reports mismatches through sticky error flags.

---
 rtl/axi_rd_arbiter3.sv | 144 ++++++++++++++
 tb/tb_axi_rd_arbiter3.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter3.sv
// axi_rd_arbiter3: round-robin arbiter sharing one AXI read channel (AR/R)
// between three read masters (0 = icache, 1 = dcache, 2 = uncached).
// One burst is in flight at a time. It is tagged with arid = master index,
// and its returning beats are routed only to the owning master.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   m_ar*                  per-master request bundles (slice i = master i)
//   m_arready              per-master request accept (one-hot or zero)
//   m_rdata/m_rlast        read data / last, broadcast to all masters
//   m_rvalid/m_rready      per-master beat handshake (owner only)
//   ar*/r*                 outer AXI read address / data channel
//   err_rid                sticky: a beat returned with rid != arid
//   err_len                sticky: rlast on the wrong beat
module axi_rd_arbiter3 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [3*ADDR_W-1:0]   m_araddr,
  input  logic [23:0]           m_arlen,
  input  logic [8:0]            m_arsize,
  input  logic [2:0]            m_arvalid,
  output logic [2:0]            m_arready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  m_rlast,
  output logic [2:0]            m_rvalid,
  input  logic [2:0]            m_rready,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  err_rid,
  output logic                  err_len
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rr_ptr;
  logic [1:0]  grant;
  logic [7:0]  beat_cnt;
  logic [1:0]  pick;
  logic        pick_vld;
  logic [2:0]  scan_idx;
  logic [2:0]  grant_oh;
  logic        take;
  logic        beat_hs;

  // Rotating priority scan: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first set wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      scan_idx = {1'b0, rr_ptr} + 3'(k);
      if (scan_idx >= 3'd3) scan_idx = scan_idx - 3'd3;
      for (int unsigned j = 0; j < 3; j++) begin
        if (!pick_vld && scan_idx == 3'(j) && m_arvalid[j]) begin
          pick     = 2'(j);
          pick_vld = 1'b1;
        end
      end
    end
  end

  // Gating with aresetn keeps m_arready low while reset is held even though
  // the request path is combinational.
  assign take = (state == IDLE) && pick_vld && aresetn;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      grant_oh[i]  = (grant == 2'(i));
      m_arready[i] = take && (pick == 2'(i));
      m_rvalid[i]  = (state == DATA) && grant_oh[i] && rvalid;
    end
  end

  assign rready  = (state == DATA) && |(m_rready & grant_oh);
  assign beat_hs = (state == DATA) && rvalid && rready;

  assign arvalid = (state == ADDR);
  assign arid    = {2'b00, grant};
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign m_rdata = rdata;
  assign m_rlast = rlast;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ADDR;
      ADDR:    if (arready) state_nxt = DATA;
      DATA:    if (beat_hs && rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      araddr   <= '0;
      arlen    <= '0;
      arsize   <= '0;
      err_rid  <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant    <= pick;
        araddr   <= m_araddr[pick*ADDR_W +: ADDR_W];
        arlen    <= m_arlen[pick*8 +: 8];
        arsize   <= m_arsize[pick*3 +: 3];
        beat_cnt <= '0;
      end
      if (beat_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (rid != {2'b00, grant}) err_rid <= 1'b1;
        // rlast must coincide exactly with beat arlen; the count only
        // flags errors and never ends the burst.
        if (rlast != (beat_cnt == arlen)) err_len <= 1'b1;
        if (rlast) rr_ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter3.sv
`timescale 1ns/1ps
module tb_axi_rd_arbiter3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [3*AW-1:0] m_araddr;
  logic [23:0]     m_arlen;
  logic [8:0]      m_arsize;
  logic [2:0]      m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0]   m_rdata;
  logic            m_rlast;
  logic [3:0]      arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [3:0]      rid;
  logic [DW-1:0]   rdata;
  logic            rlast, rvalid, rready;
  logic            err_rid, err_len;

  always #5 aclk = ~aclk;

  axi_rd_arbiter3 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_rid(err_rid), .err_len(err_len)
  );

  typedef struct {logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;} ar_t;
  typedef struct {int unsigned m; logic [31:0] data; logic last;} beat_t;
  typedef struct {logic [31:0] data; logic [3:0] id; logic last;} sbeat_t;

  int unsigned exp_grant[$];
  ar_t         exp_ar[$];
  beat_t       exp_beat[$];
  sbeat_t      slave_q[$];

  int errors = 0;
  int checks = 0;

  logic [2:0] keep;
  int         ar_stall;
  logic       rid_force_en;
  logic [3:0] rid_force;
  int         last_at;
  int         grants_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a
  // grant, an AR handshake or a routed R beat.
  initial begin : monitor
    int unsigned g;
    ar_t   a;
    beat_t b;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (m_arready != 3'b000) begin
          if (exp_grant.size() == 0) chk("grant_unexpected", m_arready, 0);
          else begin
            g = exp_grant.pop_front();
            chk("grant", m_arready, 64'(1) << g);
          end
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", arvalid, 0);
          else begin
            a = exp_ar.pop_front();
            chk("arid", arid, a.id);
            chk("araddr", araddr, a.addr);
            chk("arlen", arlen, a.len);
            chk("arsize", arsize, a.size);
            chk("arburst", arburst, 2'b01);
            chk("ar_consts", {arlock, arcache, arprot}, 0);
          end
        end
        if (m_rvalid != 3'b000) begin
          chk("rvalid_onehot", $countones(m_rvalid), 1);
          for (int i = 0; i < 3; i++) begin
            if (m_rvalid[i]) begin
              chk("rready_follow", rready, m_rready[i]);
              if (m_rready[i]) begin
                if (exp_beat.size() == 0) chk("beat_unexpected", m_rvalid, 0);
                else begin
                  b = exp_beat.pop_front();
                  chk("beat_master", i, b.m);
                  chk("beat_data", m_rdata, b.data);
                  chk("beat_last", m_rlast, b.last);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic drive_r();
    if (slave_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = slave_q[0].data;
      rid    = slave_q[0].id;
      rlast  = slave_q[0].last;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
  endtask

  // One clock: models master request drop after acceptance and the outer
  // slave (AR accept delay, beat generation data = addr + 4*beat).
  task automatic step();
    logic [2:0]  acc;
    logic        ar_hs, r_hs;
    logic [3:0]  s_id;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    int          n;
    sbeat_t      sb;
    @(negedge aclk);
    acc    = m_arready & m_arvalid;
    ar_hs  = arvalid & arready;
    r_hs   = rvalid & rready;
    s_id   = arid;
    s_addr = araddr;
    s_len  = arlen;
    @(posedge aclk);
    #1;
    m_arvalid = m_arvalid & ~(acc & ~keep);
    grants_seen += $countones(acc);
    if (r_hs && slave_q.size() > 0) slave_q.delete(0);
    if (ar_hs) begin
      n = (last_at >= 0) ? last_at : int'(s_len);
      for (int k = 0; k <= n; k++) begin
        sb.data = s_addr + 32'(4 * k);
        sb.id   = rid_force_en ? rid_force : s_id;
        sb.last = (k == n);
        slave_q.push_back(sb);
      end
    end
    if (ar_stall > 0) ar_stall--;
    arready = (ar_stall == 0);
    drive_r();
  endtask

  task automatic set_req(input int unsigned i, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    m_araddr[i*32 +: 32] = addr;
    m_arlen[i*8 +: 8]    = len;
    m_arsize[i*3 +: 3]   = size;
    m_arvalid[i]         = 1'b1;
  endtask

  task automatic expect_burst(input int unsigned m, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input int nb);
    ar_t   a;
    beat_t b;
    exp_grant.push_back(m);
    a.id = 4'(m); a.addr = addr; a.len = len; a.size = size;
    exp_ar.push_back(a);
    for (int k = 0; k < nb; k++) begin
      b.m = m; b.data = addr + 32'(4 * k); b.last = (k == nb - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_grant.size() != 0 || exp_ar.size() != 0 || exp_beat.size() != 0 ||
            slave_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_done_in_budget"}, (n < 200), 1);
    if (n >= 200) begin
      exp_grant.delete(); exp_ar.delete(); exp_beat.delete(); slave_q.delete();
      drive_r();
    end
  endtask

  task automatic wait_beats_left(input int left);
    int n;
    n = 0;
    while (exp_beat.size() > left && n < 100) begin
      step();
      n++;
    end
    chk("beats_progress", (n < 100), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    aresetn = 1'b1;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arvalid = '0; m_rready = 3'b111;
    arready = 1'b1; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    keep = '0; ar_stall = 0; rid_force_en = 1'b0; rid_force = '0; last_at = -1;
    grants_seen = 0;
    #1 aresetn = 1'b0;
    #11;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_arid", arid, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_err", {err_rid, err_len}, 0);

    // All three request continuously from reset: grant order 0,1,2,0.
    set_req(0, 32'h0000_1000, 8'd1, 3'd2);
    set_req(1, 32'h0000_1100, 8'd1, 3'd1);
    set_req(2, 32'h0000_1200, 8'd1, 3'd0);
    keep = 3'b111;
    #1 chk("rst_m_arready", m_arready, 0);
    expect_burst(0, 32'h0000_1000, 8'd1, 3'd2, 2);
    expect_burst(1, 32'h0000_1100, 8'd1, 3'd1, 2);
    expect_burst(2, 32'h0000_1200, 8'd1, 3'd0, 2);
    expect_burst(0, 32'h0000_1000, 8'd1, 3'd2, 2);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    n = 0;
    while (grants_seen < 4 && n < 100) begin step(); n++; end
    chk("cont_grants", grants_seen, 4);
    m_arvalid = '0;
    keep = '0;
    wait_done("cont");

    // Single request from master 1; arvalid one cycle after the grant.
    set_req(1, 32'h1FC0_0100, 8'd3, 3'd2);
    expect_burst(1, 32'h1FC0_0100, 8'd3, 3'd2, 4);
    step();
    chk("ar_latency_arvalid", arvalid, 1);
    chk("ar_latency_arid", arid, 4'd1);
    wait_done("single");

    // rr_ptr is now 2: simultaneous 0 and 2 -> 2 first, then 0.
    set_req(0, 32'h0000_A000, 8'd0, 3'd2);
    set_req(2, 32'h0000_B000, 8'd0, 3'd2);
    expect_burst(2, 32'h0000_B000, 8'd0, 3'd2, 1);
    expect_burst(0, 32'h0000_A000, 8'd0, 3'd2, 1);
    wait_done("rr_ptr2");

    // Owner stalls for 5 cycles mid-burst.
    set_req(0, 32'h0000_2000, 8'd3, 3'd2);
    expect_burst(0, 32'h0000_2000, 8'd3, 3'd2, 4);
    wait_beats_left(3);
    m_rready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_rready", rready, 0);
      chk("stall_m_rvalid", m_rvalid, 3'b001);
      chk("stall_no_beat", exp_beat.size(), 3);
    end
    m_rready[0] = 1'b1;
    wait_done("stall");

    // arready low 10 cycles; master 1 arrives during ADDR and must wait.
    ar_stall = 11;
    arready = 1'b0;
    set_req(2, 32'h0000_3000, 8'd0, 3'd2);
    expect_burst(2, 32'h0000_3000, 8'd0, 3'd2, 1);
    step();
    set_req(1, 32'h0000_4000, 8'd1, 3'd2);
    expect_burst(1, 32'h0000_4000, 8'd1, 3'd2, 2);
    for (int c = 0; c < 10; c++) begin
      chk("arstall_arvalid", arvalid, 1);
      chk("arstall_araddr", araddr, 32'h0000_3000);
      chk("arstall_m_arready", m_arready, 0);
      step();
    end
    wait_done("arstall");

    // Wrong rid on a grant-0 burst.
    rid_force_en = 1'b1;
    rid_force = 4'd2;
    set_req(0, 32'h0000_5000, 8'd0, 3'd2);
    expect_burst(0, 32'h0000_5000, 8'd0, 3'd2, 1);
    wait_done("err_rid");
    rid_force_en = 1'b0;
    chk("err_rid_set", err_rid, 1);
    chk("err_len_clear", err_len, 0);

    // Early rlast on beat 1 of an arlen=3 burst.
    last_at = 1;
    set_req(0, 32'h0000_6000, 8'd3, 3'd2);
    expect_burst(0, 32'h0000_6000, 8'd3, 3'd2, 2);
    wait_done("err_len");
    last_at = -1;
    chk("err_len_set", err_len, 1);
    chk("err_rid_sticky", err_rid, 1);

    // Reset during DATA, then the first grant restarts from rr_ptr=0.
    set_req(2, 32'h0000_7000, 8'd3, 3'd2);
    expect_burst(2, 32'h0000_7000, 8'd3, 3'd2, 4);
    wait_beats_left(3);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_arlen", arlen, 0);
    chk("mid_rst_arsize", arsize, 0);
    chk("mid_rst_arid", arid, 0);
    chk("mid_rst_m_rvalid", m_rvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_err", {err_rid, err_len}, 0);
    exp_grant.delete(); exp_ar.delete(); exp_beat.delete(); slave_q.delete();
    drive_r();
    set_req(0, 32'h0000_8000, 8'd0, 3'd2);
    set_req(2, 32'h0000_9000, 8'd0, 3'd2);
    #1 chk("mid_rst_m_arready", m_arready, 0);
    step();
    step();
    expect_burst(0, 32'h0000_8000, 8'd0, 3'd2, 1);
    expect_burst(2, 32'h0000_9000, 8'd0, 3'd2, 1);
    aresetn = 1'b1;
    wait_done("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
